// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_param
//  Description : Parametrised register file with per-entry reset image,
//                optional hardwired zero register, write-to-read bypass,
//                pending-write scoreboard and a sequenced bulk-clear engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_param #(
    parameter int                                  DATA_W   = 8,
    parameter int                                  ADDR_W   = 2,
    parameter logic [(2**ADDR_W)*DATA_W-1:0]       RST_VALS = {8'd30, 8'd20, 8'd10, 8'd5},
    parameter bit                                  ZERO_REG = 1'b0,
    parameter bit                                  BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic              wr_ready,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_idx,
    output logic              busy1,
    output logic              busy2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int                c_DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(c_DEPTH - 1);

    // Clear engine states
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_CLEAR = 1'b1;

    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] r_busy;
    logic [0:0]         r_state;
    logic [ADDR_W-1:0]  r_cnt;
    logic               r_clr_done;

    logic               w_wr_en;
    logic               w_wr_zero;
    logic [c_DEPTH-1:0] w_busy_nxt;

    assign clr_busy  = (r_state == c_CLEAR);
    assign clr_done  = r_clr_done;
    assign wr_ready  = ~clr_busy;
    assign w_wr_en   = reg_write & wr_ready;
    // A write aimed at the hardwired zero entry must never land in storage
    assign w_wr_zero = ZERO_REG && (write_reg == '0);

    // Read mux: stored value, optionally overridden by a same-cycle write,
    // with the zero register taking priority over everything.
    function automatic logic [DATA_W-1:0] f_read(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] v;
        v = stored;
        if (BYPASS && w_wr_en && (write_reg == addr))
            v = write_data;
        if (ZERO_REG && (addr == '0))
            v = '0;
        return v;
    endfunction

    // Combinational read ports
    always_comb begin
        read_data1 = f_read(read_reg1, r_mem[read_reg1]);
        read_data2 = f_read(read_reg2, r_mem[read_reg2]);
    end

    // Pending flags are visible only from storage; a same-cycle set shows next cycle
    assign busy1 = r_busy[read_reg1];
    assign busy2 = r_busy[read_reg2];

    // Next scoreboard image: write clears, set wins over write, clear start wipes all
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_en)
            w_busy_nxt[write_reg] = 1'b0;
        if (sb_set && !clr_busy)
            w_busy_nxt[sb_idx] = 1'b1;
        if (clr_req && !clr_busy)
            w_busy_nxt = '0;
        if (ZERO_REG)
            w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    // Storage plus clear sequencer; the clear walks entries 0..DEPTH-1 one per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++)
                r_mem[i] <= (ZERO_REG && (i == 0)) ? '0 : RST_VALS[i*DATA_W +: DATA_W];
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= 1'b0;
            if (r_state == c_CLEAR) begin
                r_mem[r_cnt] <= '0;
                r_cnt        <= r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    r_state    <= c_IDLE;
                    r_clr_done <= 1'b1;
                end
            end else begin
                if (w_wr_en && !w_wr_zero)
                    r_mem[write_reg] <= write_data;
                if (clr_req) begin
                    r_state <= c_CLEAR;
                    r_cnt   <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_param
//  Description : Self-checking bench for regfile_param (bypass, no-bypass and
//                zero-register/wide configurations).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus for the 8x4 bypass and non-bypass instances
    logic [1:0] ra1 = '0, ra2 = '0, wa = '0, sbi = '0;
    logic [7:0] wd = '0;
    logic       we = 1'b0, sb = 1'b0, clr = 1'b0;

    logic [7:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic       a_rdy, a_b1, a_b2, a_cb, a_cd;
    logic       b_rdy, b_b1, b_b2, b_cb, b_cd;

    // Stimulus for the 16x8 zero-register instance
    logic [2:0]  z_ra1 = '0, z_ra2 = '0, z_wa = '0, z_sbi = '0;
    logic [15:0] z_wd = '0;
    logic        z_we = 1'b0, z_sb = 1'b0, z_clr = 1'b0;
    logic [15:0] z_rd1, z_rd2;
    logic        z_rdy, z_b1, z_b2, z_cb, z_cd;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] c_rst [4] = '{8'd5, 8'd10, 8'd20, 8'd30};

    regfile_param #(.BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .read_reg1(ra1), .read_reg2(ra2),
        .read_data1(a_rd1), .read_data2(a_rd2), .reg_write(we), .write_reg(wa),
        .write_data(wd), .wr_ready(a_rdy), .sb_set(sb), .sb_idx(sbi),
        .busy1(a_b1), .busy2(a_b2), .clr_req(clr), .clr_busy(a_cb), .clr_done(a_cd));

    regfile_param #(.BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .read_reg1(ra1), .read_reg2(ra2),
        .read_data1(b_rd1), .read_data2(b_rd2), .reg_write(we), .write_reg(wa),
        .write_data(wd), .wr_ready(b_rdy), .sb_set(sb), .sb_idx(sbi),
        .busy1(b_b1), .busy2(b_b2), .clr_req(clr), .clr_busy(b_cb), .clr_done(b_cd));

    regfile_param #(
        .DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1),
        .RST_VALS(128'h7007_6006_5005_4004_3003_2002_1001_0F00)
    ) dut_z (
        .clk(clk), .rst(rst), .read_reg1(z_ra1), .read_reg2(z_ra2),
        .read_data1(z_rd1), .read_data2(z_rd2), .reg_write(z_we), .write_reg(z_wa),
        .write_data(z_wd), .wr_ready(z_rdy), .sb_set(z_sb), .sb_idx(z_sbi),
        .busy1(z_b1), .busy2(z_b2), .clr_req(z_clr), .clr_busy(z_cb), .clr_done(z_cd));

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {we, sb, clr, z_we, z_sb, z_clr} = '0;
        ra1 = '0; ra2 = '0; wa = '0; sbi = '0; wd = '0;
        z_ra1 = '0; z_ra2 = '0; z_wa = '0; z_sbi = '0; z_wd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ra1 = 2'(i); ra2 = 2'(3 - i);
            #1;
            n_cmp++;
            if ({a_rd1, a_rd2, b_rd1, b_rd2} !== {c_rst[i], c_rst[3-i], c_rst[i], c_rst[3-i]}) begin
                n_bad++;
                $display("FAIL reset_vals[%0d]: got %h expected %h", i, {a_rd1, a_rd2, b_rd1, b_rd2},
                         {c_rst[i], c_rst[3-i], c_rst[i], c_rst[3-i]});
            end
        end
        n_cmp++;
        if ({a_b1, a_b2, a_rdy, a_cb, a_cd, b_b1, b_b2, b_rdy, b_cb, b_cd, z_rdy, z_cb} !== 12'b001000010010) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 001000010010",
                     {a_b1, a_b2, a_rdy, a_cb, a_cd, b_b1, b_b2, b_rdy, b_cb, b_cd, z_rdy, z_cb});
        end
    endtask

    task automatic test_bypass();
        ra1 = 2'd2; we = 1'b1; wa = 2'd2; wd = 8'hA5;
        #2;
        n_cmp++;
        if (a_rd1 !== 8'hA5) begin n_bad++; $display("FAIL bypass_same_cycle: got %h expected a5", a_rd1); end
        n_cmp++;
        if (b_rd1 !== 8'd20) begin n_bad++; $display("FAIL nobypass_same_cycle: got %h expected 14", b_rd1); end
        tick();
        we = 1'b0;
        #2;
        n_cmp++;
        if ({a_rd1, b_rd1} !== 16'hA5A5) begin n_bad++; $display("FAIL bypass_next_cycle: got %h expected a5a5", {a_rd1, b_rd1}); end
    endtask

    task automatic test_scoreboard();
        ra2 = 2'd3; sb = 1'b1; sbi = 2'd3;
        #2;
        n_cmp++;
        if (a_b2 !== 1'b0) begin n_bad++; $display("FAIL sb_no_same_cycle: got %b expected 0", a_b2); end
        tick();
        sb = 1'b0;
        #2;
        n_cmp++;
        if ({a_b2, b_b2} !== 2'b11) begin n_bad++; $display("FAIL sb_set: got %b expected 11", {a_b2, b_b2}); end
        we = 1'b1; wa = 2'd3; wd = 8'd7; sb = 1'b1; sbi = 2'd3;
        tick();
        we = 1'b0; sb = 1'b0;
        #2;
        n_cmp++;
        if ({a_b2, a_rd2} !== {1'b1, 8'd7}) begin n_bad++; $display("FAIL sb_set_wins: got %h expected 107", {a_b2, a_rd2}); end
        we = 1'b1; wa = 2'd3; wd = 8'd9;
        tick();
        we = 1'b0;
        #2;
        n_cmp++;
        if ({a_b2, a_rd2, b_rd2} !== {1'b0, 8'd9, 8'd9}) begin
            n_bad++; $display("FAIL sb_write_clears: got %h expected 00909", {a_b2, a_rd2, b_rd2});
        end
    endtask

    task automatic test_clear();
        do_reset();
        sb = 1'b1; sbi = 2'd1;
        tick();
        sb = 1'b0; clr = 1'b1;
        #2;
        n_cmp++;
        if (a_cb !== 1'b0) begin n_bad++; $display("FAIL clr_start_latency: got %b expected 0", a_cb); end
        tick();
        clr = 1'b0;
        ra1 = 2'd1;
        #1;
        n_cmp++;
        if (a_b1 !== 1'b0) begin n_bad++; $display("FAIL clr_wipes_busy: got %b expected 0", a_b1); end
        for (int k = 0; k < 4; k++) begin
            ra1 = 2'(k);
            ra2 = (k == 0) ? 2'd0 : 2'(k - 1);
            if (k == 1) begin we = 1'b1; wa = 2'd3; wd = 8'hFF; sb = 1'b1; sbi = 2'd2; end
            if (k == 2) clr = 1'b1;
            #1;
            n_cmp++;
            if ({a_cb, a_rdy, a_cd, a_rd1} !== {3'b100, c_rst[k]}) begin
                n_bad++; $display("FAIL clr_cycle[%0d]: got %h expected %h", k, {a_cb, a_rdy, a_cd, a_rd1}, {3'b100, c_rst[k]});
            end
            if (k > 0) begin
                n_cmp++;
                if (a_rd2 !== 8'd0) begin n_bad++; $display("FAIL clr_order[%0d]: got %h expected 00", k, a_rd2); end
            end
            tick();
            we = 1'b0; clr = 1'b0; sb = 1'b0;
        end
        #1;
        n_cmp++;
        if ({a_cb, a_cd, b_cd} !== 3'b011) begin n_bad++; $display("FAIL clr_done_pulse: got %b expected 011", {a_cb, a_cd, b_cd}); end
        for (int i = 0; i < 4; i++) begin
            ra1 = 2'(i); ra2 = 2'(i);
            #1;
            n_cmp++;
            if ({a_rd1, b_rd2, 7'b0, a_b1} !== 24'h0) begin
                n_bad++; $display("FAIL clr_all_zero[%0d]: got %h expected 000000", i, {a_rd1, b_rd2, 7'b0, a_b1});
            end
        end
        tick();
        #1;
        n_cmp++;
        if ({a_cb, a_cd} !== 2'b00) begin n_bad++; $display("FAIL clr_done_once: got %b expected 00", {a_cb, a_cd}); end
    endtask

    task automatic test_reset_mid_clear();
        do_reset();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        #2;
        n_cmp++;
        if (a_cb !== 1'b1) begin n_bad++; $display("FAIL midclr_active: got %b expected 1", a_cb); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_cb, a_cd, a_rdy} !== 3'b001) begin n_bad++; $display("FAIL midclr_abort: got %b expected 001", {a_cb, a_cd, a_rdy}); end
        for (int i = 0; i < 4; i++) begin
            ra1 = 2'(i);
            #1;
            n_cmp++;
            if (a_rd1 !== c_rst[i]) begin n_bad++; $display("FAIL midclr_restore[%0d]: got %h expected %h", i, a_rd1, c_rst[i]); end
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({a_cb, a_cd} !== 2'b00) begin n_bad++; $display("FAIL midclr_no_done[%0d]: got %b expected 00", c, {a_cb, a_cd}); end
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        z_ra1 = 3'd0; z_ra2 = 3'd7;
        #1;
        n_cmp++;
        if ({z_rd1, z_rd2} !== 32'h0000_7007) begin n_bad++; $display("FAIL zero_reset: got %h expected 00007007", {z_rd1, z_rd2}); end
        z_we = 1'b1; z_wa = 3'd0; z_wd = 16'hFFFF;
        #1;
        n_cmp++;
        if (z_rd1 !== 16'h0) begin n_bad++; $display("FAIL zero_over_bypass: got %h expected 0000", z_rd1); end
        tick();
        z_we = 1'b0; z_sb = 1'b1; z_sbi = 3'd0;
        #1;
        n_cmp++;
        if (z_rd1 !== 16'h0) begin n_bad++; $display("FAIL zero_ignores_write: got %h expected 0000", z_rd1); end
        tick();
        z_sb = 1'b0;
        #1;
        n_cmp++;
        if (z_b1 !== 1'b0) begin n_bad++; $display("FAIL zero_never_busy: got %b expected 0", z_b1); end
        z_we = 1'b1; z_wa = 3'd7; z_wd = 16'h1234;
        #1;
        n_cmp++;
        if (z_rd2 !== 16'h1234) begin n_bad++; $display("FAIL zero_cfg_bypass: got %h expected 1234", z_rd2); end
        tick();
        z_we = 1'b0; z_sb = 1'b1; z_sbi = 3'd7;
        #1;
        n_cmp++;
        if (z_rd2 !== 16'h1234) begin n_bad++; $display("FAIL zero_cfg_r7: got %h expected 1234", z_rd2); end
        tick();
        z_sb = 1'b0;
        #1;
        n_cmp++;
        if (z_b2 !== 1'b1) begin n_bad++; $display("FAIL zero_cfg_busy7: got %b expected 1", z_b2); end
    endtask

    // Random traffic checked against a cycle-level behavioural model
    task automatic test_random();
        logic [7:0] m_mem [4];
        bit         m_busy [4];
        int         m_left;
        bit         m_done;
        bit         acc;
        logic [7:0] e_a1, e_a2;
        logic [3:0] e_bz;
        logic [5:0] e_fl;
        do_reset();
        for (int i = 0; i < 4; i++) begin m_mem[i] = c_rst[i]; m_busy[i] = 1'b0; end
        m_left = 0; m_done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            ra1 = 2'($urandom_range(0, 3)); ra2 = 2'($urandom_range(0, 3));
            wa  = 2'($urandom_range(0, 3)); sbi = 2'($urandom_range(0, 3));
            we  = 1'($urandom_range(0, 1)); wd = 8'($urandom);
            sb  = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 24) == 0);
            #2;
            acc  = we && (m_left == 0);
            e_a1 = (acc && wa == ra1) ? wd : m_mem[ra1];
            e_a2 = (acc && wa == ra2) ? wd : m_mem[ra2];
            e_bz = {m_busy[ra1], m_busy[ra2], m_busy[ra1], m_busy[ra2]};
            e_fl = {m_left == 0, m_left > 0, m_done, m_left == 0, m_left > 0, m_done};
            n_cmp++;
            if ({a_rd1, a_rd2, b_rd1, b_rd2} !== {e_a1, e_a2, m_mem[ra1], m_mem[ra2]}) begin
                n_bad++; $display("FAIL rand_rdata[%0d]: got %h expected %h", c, {a_rd1, a_rd2, b_rd1, b_rd2},
                                  {e_a1, e_a2, m_mem[ra1], m_mem[ra2]});
            end
            n_cmp++;
            if ({a_b1, a_b2, b_b1, b_b2} !== e_bz) begin
                n_bad++; $display("FAIL rand_busy[%0d]: got %b expected %b", c, {a_b1, a_b2, b_b1, b_b2}, e_bz);
            end
            n_cmp++;
            if ({a_rdy, a_cb, a_cd, b_rdy, b_cb, b_cd} !== e_fl) begin
                n_bad++; $display("FAIL rand_flags[%0d]: got %b expected %b", c, {a_rdy, a_cb, a_cd, b_rdy, b_cb, b_cd}, e_fl);
            end
            if (m_left > 0) begin
                m_mem[4 - m_left] = 8'd0;
                m_left--;
                m_done = (m_left == 0);
            end else begin
                m_done = 1'b0;
                if (we) begin m_mem[wa] = wd; m_busy[wa] = 1'b0; end
                if (sb) m_busy[sbi] = 1'b1;
                if (clr) begin
                    m_left = 4;
                    for (int i = 0; i < 4; i++) m_busy[i] = 1'b0;
                end
            end
            tick();
        end
        {we, sb, clr} = '0;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_scoreboard();
        test_clear();
        test_reset_mid_clear();
        test_zero_reg();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
